vga_sync_decoder: RTL
=====================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- H_ACT, 640, active pixels per line
- H_TOTAL, 800, pixels per line
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- V_ACT, 480, active lines per frame
- V_TOTAL, 525, lines per frame

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  sole clock.
- rst_l  in  1  asynchronous active-low reset.
- pix_en  in  1  pixel strobe; all state advances only on clk edges with pix_en=1.
- vga_hs_l  in  1  hsync, active low.
- vga_vs_l  in  1  vsync, active low.
- vga_rgb  in  3  pixel colour {r,g,b}.
- vga_row  out  9  recovered active row, 0..479.
- vga_col  out  10  recovered active column, 0..639.
- vga_display  out  1  recovered pixel is in the active region and decoder is locked.
- pix_rgb  out  3  recovered pixel colour, aligned with vga_row/vga_col.
- locked  out  1  timing lock indicator.
- frame_start  out  1  one-pixel pulse on a vsync falling edge.
- sync_err  out  1  one-pixel pulse on loss of lock.

REQ-003 There SHALL be one clock (clk) and one asynchronous active-low reset (rst_l).

Function
REQ-004 hs_l, vs_l and rgb SHALL each pass through two pix_en-gated register stages (s1, then s2).
REQ-005 h_fall SHALL be defined as hs_s1==0 and hs_s2==1; v_fall SHALL be defined as vs_s1==0 and vs_s2==1.
REQ-006 hcnt (10 bit) SHALL behave as follows:
- on h_fall, load 0;
- otherwise increment, saturating at 1023.
- Consequence: hcnt==0 holds in the second pixel after the first low hsync sample.
REQ-007 vcnt (10 bit) SHALL behave as follows:
- on v_fall, load 0 (v_fall has priority over h_fall);
- on h_fall alone, increment, saturating at 1023.
REQ-008 line_ok SHALL be true at an h_fall when hcnt==H_TOTAL-1; frame_ok SHALL be true at a v_fall when vcnt==V_TOTAL-1.
REQ-009 The lock FSM SHALL have three states: UNLOCKED, TRACK, LOCKED.
- UNLOCKED: v_fall -> TRACK.
- TRACK: h_fall with !line_ok -> UNLOCKED; v_fall with frame_ok -> LOCKED; v_fall with !frame_ok -> remain in TRACK.
- LOCKED: h_fall with !line_ok, or v_fall with !frame_ok, or hcnt reaching 1023 -> UNLOCKED.
- TRACK: hcnt reaching 1023 -> UNLOCKED.
REQ-010 sync_err SHALL pulse for one pixel only on a LOCKED->UNLOCKED transition; locked SHALL be high exactly when the FSM is in LOCKED.
REQ-011 frame_start SHALL equal v_fall in every state.
REQ-012 vga_display SHALL be high when locked and H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACT and V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACT.
REQ-013 While vga_display is high:
- vga_col SHALL equal hcnt-(H_SYNC+H_BP);
- vga_row SHALL equal vcnt-(V_SYNC+V_BP);
- pix_rgb SHALL equal rgb_s2.
REQ-014 While vga_display is low, vga_col, vga_row and pix_rgb SHALL be 0.
REQ-015 With pix_en=0, all registers SHALL hold and all pulses SHALL be 0.
REQ-016 Subtractions SHALL be evaluated at 10 bits, and vga_row SHALL be truncated to 9 bits.

Reset
REQ-017 Asserting rst_l low SHALL immediately force:
- s1 and s2 sync stages to 1;
- rgb stages to 0;
- hcnt and vcnt to 0;
- the FSM to UNLOCKED;
- all outputs to 0.
REQ-018 Reset asserted mid-frame SHALL discard lock; after release, lock SHALL require a fresh v_fall plus one full good frame.

Verification
REQ-019 Drive ideal 640x480 timing with pix_en every clk and rgb encoding column/80 -> locked rises at the second vsync falling edge plus 1 pixel, and each row shows pix_rgb 0 for cols 0-79 through 7 for cols 560-639.
REQ-020 Once locked, check alignment -> vga_col==0 with pix_rgb equal to the first active pixel's colour, and vga_col==639 on the last active pixel.
REQ-021 Lengthen one line to 801 pixels while locked -> sync_err pulses once at that line's end, locked=0, vga_display=0, and relock follows after two further good vsync edges.
REQ-022 Hold hs_l high for 1100 pixels while locked -> unlock with sync_err when hcnt reaches 1023.
REQ-023 pix_en at 50% duty -> identical recovered row/col/rgb sequence in pix_en cycles.
REQ-024 Assert rst_l mid-line while locked -> all outputs 0 asynchronously, and no sync_err pulse.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//
// Recovers pixel coordinates and colour from a raw VGA stream (active-low
// hsync/vsync plus 3-bit RGB) sampled on pixel strobes. Sync and colour pass
// through two strobe-gated register stages. Falling edges of the synchronised
// hsync/vsync drive a column counter (hcnt) and a line counter (vcnt). A lock
// FSM accepts the timing once a full frame with correct line and frame
// lengths has been observed. The recovered row/column/colour are presented
// only while locked and inside the active window.
//
// Ports
//   clk          in   sole clock
//   rst_l        in   asynchronous active-low reset
//   pix_en       in   pixel strobe; state advances only when high
//   vga_hs_l     in   hsync, active low
//   vga_vs_l     in   vsync, active low
//   vga_rgb      in   [2:0] pixel colour {r,g,b}
//   vga_row      out  [8:0] recovered active row
//   vga_col      out  [9:0] recovered active column
//   vga_display  out  recovered pixel is active and decoder is locked
//   pix_rgb      out  [2:0] recovered colour, aligned with row/col
//   locked       out  timing lock indicator
//   frame_start  out  one-pixel pulse on a vsync falling edge
//   sync_err     out  one-pixel pulse on loss of lock
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int H_ACT   = 640,
   parameter int H_TOTAL = 800,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33,
   parameter int V_ACT   = 480,
   parameter int V_TOTAL = 525
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       pix_en,
   input  logic       vga_hs_l,
   input  logic       vga_vs_l,
   input  logic [2:0] vga_rgb,
   output logic [8:0] vga_row,
   output logic [9:0] vga_col,
   output logic       vga_display,
   output logic [2:0] pix_rgb,
   output logic       locked,
   output logic       frame_start,
   output logic       sync_err
);

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACT);
   localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACT);
   localparam logic [9:0] CNT_MAX = 10'd1023;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_TRACK    = 2'd1,
      ST_LOCKED   = 2'd2
   } state_e;

   logic       hs_s1_q, hs_s2_q;
   logic       vs_s1_q, vs_s2_q;
   logic [2:0] rgb_s1_q, rgb_s2_q;
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   state_e     state_q, state_d;

   logic       h_fall, v_fall;
   logic       line_ok, frame_ok, hcnt_sat;
   logic       h_act, v_act;

   // Two-stage sampling of sync and colour, advanced only on pixel strobes.
   // Sync stages reset high so no spurious edge appears after reset.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         hs_s1_q  <= 1'b1;
         hs_s2_q  <= 1'b1;
         vs_s1_q  <= 1'b1;
         vs_s2_q  <= 1'b1;
         rgb_s1_q <= 3'd0;
         rgb_s2_q <= 3'd0;
      end else if (pix_en) begin
         hs_s1_q  <= vga_hs_l;
         hs_s2_q  <= hs_s1_q;
         vs_s1_q  <= vga_vs_l;
         vs_s2_q  <= vs_s1_q;
         rgb_s1_q <= vga_rgb;
         rgb_s2_q <= rgb_s1_q;
      end
   end

   // Edge events are qualified by the strobe so that every pulse and every
   // state change derived from them is zero while pix_en is low.
   assign h_fall   = pix_en & ~hs_s1_q & hs_s2_q;
   assign v_fall   = pix_en & ~vs_s1_q & vs_s2_q;
   assign line_ok  = (hcnt_q == H_LAST);
   assign frame_ok = (vcnt_q == V_LAST);
   assign hcnt_sat = pix_en & (hcnt_q == CNT_MAX);

   // hcnt indexes the pixel held in the second colour stage, so the
   // coordinates and rgb_s2_q line up without extra delay.
   always_comb begin
      hcnt_d = hcnt_q;
      if (h_fall) begin
         hcnt_d = 10'd0;
      end else if (pix_en && (hcnt_q != CNT_MAX)) begin
         hcnt_d = hcnt_q + 10'd1;
      end
   end

   always_comb begin
      vcnt_d = vcnt_q;
      if (v_fall) begin
         vcnt_d = 10'd0;
      end else if (h_fall && (vcnt_q != CNT_MAX)) begin
         vcnt_d = vcnt_q + 10'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         hcnt_q <= 10'd0;
         vcnt_q <= 10'd0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   // Lock FSM: state register
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= ST_UNLOCKED;
      end else begin
         state_q <= state_d;
      end
   end

   // Lock FSM: next state. A bad line or a runaway hcnt drops lock from
   // both TRACK and LOCKED; a bad line takes precedence over a frame edge
   // arriving in the same pixel.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_UNLOCKED: begin
            if (v_fall) state_d = ST_TRACK;
         end
         ST_TRACK: begin
            if ((h_fall && !line_ok) || hcnt_sat) begin
               state_d = ST_UNLOCKED;
            end else if (v_fall && frame_ok) begin
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if ((h_fall && !line_ok) || (v_fall && !frame_ok) || hcnt_sat) begin
               state_d = ST_UNLOCKED;
            end
         end
         default: state_d = ST_UNLOCKED;
      endcase
   end

   assign h_act = (hcnt_q >= H_START) && (hcnt_q < H_END);
   assign v_act = (vcnt_q >= V_START) && (vcnt_q < V_END);

   // Lock FSM: outputs. Everything is derived from registers that reset
   // asynchronously, so all outputs drop to zero as soon as rst_l falls.
   always_comb begin
      locked      = (state_q == ST_LOCKED);
      sync_err    = (state_q == ST_LOCKED) && (state_d == ST_UNLOCKED);
      frame_start = v_fall;
      vga_display = (state_q == ST_LOCKED) && h_act && v_act;
      vga_col     = 10'd0;
      vga_row     = 9'd0;
      pix_rgb     = 3'd0;
      if (vga_display) begin
         vga_col = hcnt_q - H_START;
         vga_row = 9'(vcnt_q - V_START);
         pix_rgb = rgb_s2_q;
      end
   end

endmodule
